fb_arbiter: RTL and testbench

- Owns the single-port 8-bit framebuffer RAM (160x120, each word displayed as a 4x4 pixel block).
- Shares the RAM between the display scan-out path and one drawing requester:
  - the display path takes fixed-priority read slots;
  - the drawer writes through a valid/ready handshake.
- Runs a blanking-time clear sequencer and emits a frame-start strobe.
- Sits between vga_driver (next_x/next_y in, color_in out) and the drawing logic.
- Runs in the 25 MHz pixel domain.

---
 rtl/fb_arbiter.sv | 142 ++++++++++++++
 tb/tb_fb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: owns the single-port framebuffer RAM, sharing it between the
// display scan-out (fixed-priority read slots), one valid/ready drawer and a
// blanking-time clear sequencer. Also emits the per-frame start strobe.
module fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    output logic [7:0]        color_out,
    output logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [7:0]        wr_color,
    input  logic              clear_req,
    input  logic [7:0]        clear_color,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {SERVE, CLEAR_WAIT, CLEAR} state_t;

    localparam logic [9:0]        H_LIM    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
    localparam logic [7:0]        X_LIM    = 8'(FB_W);
    localparam logic [6:0]        Y_LIM    = 7'(FB_H);
    localparam logic [ADDR_W-1:0] ROW_W    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        clr_color;
    logic              slot_d;
    logic              vis_d;

    logic              visible;
    logic              display_slot;
    logic              vblank_start;
    logic              wr_in_range;
    logic              disp_grant;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign visible      = (next_x < H_LIM) && (next_y < V_LIM);
    assign display_slot = visible && (next_x[SCALE_LOG2-1:0] == '0);
    assign vblank_start = (next_y == V_LIM) && (next_x == '0);
    assign wr_in_range  = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign disp_addr    = ADDR_W'(next_y >> SCALE_LOG2) * ROW_W + ADDR_W'(next_x >> SCALE_LOG2);
    assign wr_addr      = ADDR_W'(wr_y) * ROW_W + ADDR_W'(wr_x);
    assign frame_start  = !reset && vblank_start;

    // RAM port mux: one access per clock, CLEAR > display slot > drawer; idle under reset
    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        wr_ready   = 1'b0;
        disp_grant = 1'b0;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = clr_color;
            end else if (display_slot) begin
                ram_addr   = disp_addr;
                disp_grant = 1'b1;
            end else begin
                wr_ready = 1'b1;
                if (wr_valid && wr_in_range) begin
                    ram_we    = 1'b1;
                    ram_addr  = wr_addr;
                    ram_wdata = wr_color;
                end
            end
        end
    end

    // Clear sequencer: latch request, wait for vblank start, then sweep every word
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SERVE;
            clear_busy <= 1'b0;
            clr_cnt    <= '0;
            clr_color  <= '0;
        end else begin
            case (state)
                SERVE: begin
                    if (clear_req) begin
                        clr_color  <= clear_color;
                        clear_busy <= 1'b1;
                        state      <= CLEAR_WAIT;
                    end
                end
                CLEAR_WAIT: begin
                    if (vblank_start) begin
                        clr_cnt <= '0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        clr_cnt    <= '0;
                        clear_busy <= 1'b0;
                        state      <= SERVE;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                default: state <= SERVE;
            endcase
        end
    end

    // Display pipeline: capture read data one clock after a granted slot, blank outside the visible area
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_d    <= 1'b0;
            vis_d     <= 1'b0;
            color_out <= '0;
        end else begin
            slot_d <= disp_grant;
            vis_d  <= visible;
            if (slot_d) begin
                color_out <= ram_rdata;
            end else if (!vis_d) begin
                color_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized scoreboard bench for fb_arbiter with a behavioural
// framebuffer model; expected per-cycle status and RAM writes go into queues
// that a negedge monitor drains against the DUT.
module tb_fb_arbiter;
    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int NWORDS = FB_W * FB_H;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  next_x, next_y;
    logic [7:0]  color_out;
    logic        frame_start;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_color;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;

    always #5 clock = ~clock;

    fb_arbiter dut (
        .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
        .color_out(color_out), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port synchronous RAM, read data one clock after the address
    logic [7:0] mem [0:32767];
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        bit         ready;
        bit         fs;
        bit         busy;
        bit         we;
        bit         chk_addr;
        logic [7:0] color;
        int         addr;
    } status_t;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    status_t st_q[$];
    wr_t     wr_q[$];
    int      checks = 0;
    int      passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one status entry per clock, one write entry per observed RAM write
    initial begin : monitor
        status_t s;
        wr_t     w;
        forever begin
            @(negedge clock);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("wr_ready", 32'(wr_ready), 32'(s.ready));
                chk("frame_start", 32'(frame_start), 32'(s.fs));
                chk("clear_busy", 32'(clear_busy), 32'(s.busy));
                chk("color_out", 32'(color_out), 32'(s.color));
                chk("ram_we", 32'(ram_we), 32'(s.we));
                if (s.chk_addr) chk("ram_addr", 32'(ram_addr), 32'(s.addr));
                if (ram_we === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 32'(ram_addr), 32'hFFFF_FFFF);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_addr", 32'(ram_addr), 32'(w.addr));
                        chk("write_data", 32'(ram_wdata), 32'(w.data));
                    end
                end
            end
        end
    end

    // Reference model state
    logic [7:0] fbm [0:NWORDS-1];
    bit         m_busy = 0, m_pending = 0, m_clearing = 0;
    int         m_cidx = 0;
    logic [7:0] m_cval = '0;
    int         e1k = 2, e2k = 2;
    logic [7:0] e1v = '0, e2v = '0;
    bit         rst1 = 1;
    logic [7:0] m_col = '0;
    bit         last_acc = 0;
    bit         rnd_wr = 0;

    // Model one clock from the spec rules, queue expectations, then advance
    task automatic step();
        status_t s;
        int xi, yi, kind, wa;
        logic [7:0] v;
        bit vis, slot, vstart;
        xi = int'(next_x);
        yi = int'(next_y);
        vis    = (xi < 640) && (yi < 480);
        slot   = vis && (xi % 4 == 0);
        vstart = (yi == 480) && (xi == 0);
        // colour seen now was decided by the access two clocks ago
        if (rst1) m_col = '0;
        else if (e2k == 1) m_col = e2v;
        else if (e2k == 2) m_col = '0;
        s.color = m_col;
        s.busy  = m_busy;
        s.fs    = !reset && vstart;
        s.ready = 0; s.we = 0; s.chk_addr = 0; s.addr = 0;
        v = '0;
        if (reset) begin
            s.chk_addr = 1;
        end else if (m_clearing) begin
            s.we = 1; s.chk_addr = 1; s.addr = m_cidx;
            wr_q.push_back('{m_cidx, m_cval});
            fbm[m_cidx] = m_cval;
        end else if (slot) begin
            s.chk_addr = 1;
            s.addr = (yi / 4) * FB_W + xi / 4;
            v = fbm[s.addr];
        end else begin
            s.ready = 1;
            if (wr_valid && int'(wr_x) < FB_W && int'(wr_y) < FB_H) begin
                wa = int'(wr_y) * FB_W + int'(wr_x);
                s.we = 1; s.chk_addr = 1; s.addr = wa;
                wr_q.push_back('{wa, wr_color});
                fbm[wa] = wr_color;
            end
        end
        kind = reset ? 2 : (slot && !m_clearing) ? 1 : (!vis ? 2 : 0);
        st_q.push_back(s);
        last_acc = s.ready && wr_valid;
        e2k = e1k; e2v = e1v; e1k = kind; e1v = v; rst1 = reset;
        if (reset) begin
            m_busy = 0; m_pending = 0; m_clearing = 0;
        end else if (m_clearing) begin
            if (m_cidx == NWORDS - 1) begin m_clearing = 0; m_busy = 0; end
            else m_cidx++;
        end else if (!m_busy) begin
            if (clear_req) begin m_busy = 1; m_pending = 1; m_cval = clear_color; end
        end else if (m_pending && vstart) begin
            m_pending = 0; m_clearing = 1; m_cidx = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        if (rnd_wr && (last_acc || !wr_valid)) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_x     = 8'($urandom_range(0, 191));
            wr_y     = 7'($urandom_range(0, 127));
            wr_color = 8'($urandom);
        end
        step();
    endtask

    task automatic line(input int y, input int x0, input int n);
        for (int i = 0; i < n; i++) begin
            next_y = 10'(y);
            next_x = 10'((x0 + i) % 800);
            tick();
        end
    endtask

    task automatic vblank(input int n, input int rst_at, input int req_at);
        for (int k = 0; k < n; k++) begin
            next_y    = 10'(480 + k / 800);
            next_x    = 10'(k % 800);
            reset     = (k == rst_at);
            clear_req = (k == req_at);
            if (k == req_at) clear_color = 8'hEE;
            tick();
        end
        reset = 0;
        clear_req = 0;
    endtask

    task automatic drawer(input int x, input int y, input logic [7:0] c, input int scan_y);
        int n = 0;
        wr_valid = 1; wr_x = 8'(x); wr_y = 7'(y); wr_color = c;
        do begin
            next_y = 10'(scan_y);
            next_x = 10'(n);
            step();
            n++;
        end while (!last_acc && n < 4);
        wr_valid = 0;
    endtask

    task automatic pulse_clear(input logic [7:0] c, input int y);
        clear_req = 1; clear_color = c;
        line(y, 1, 1);
        clear_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        for (int i = 0; i < NWORDS; i++) fbm[i] = '0;
        reset = 1; next_x = '0; next_y = '0;
        wr_valid = 0; wr_x = '0; wr_y = '0; wr_color = '0;
        clear_req = 0; clear_color = '0;
        @(posedge clock);
        #1;

        // reset held during a visible scan, then first slot at (0,0)
        line(10, 100, 3);
        reset = 0;
        line(0, 0, 16);

        // word 161 = A5, then scan the 4x4 block rows including line end
        drawer(1, 1, 8'hA5, 0);
        for (int y = 4; y < 8; y++) begin
            line(y, 0, 16);
            line(y, 636, 8);
        end

        // drawer blocked by display slots; in-range and out-of-range requests
        drawer(3, 2, 8'h3C, 8);
        drawer(200, 5, 8'h99, 9);
        line(0, 8, 8);

        // randomized scan segments and drawer traffic, biased to boundaries
        rnd_wr = 1;
        for (int i = 0; i < 60; i++) begin
            line(($urandom_range(0, 3) == 0) ? 476 + $urandom_range(0, 8) : $urandom_range(0, 479),
                 ($urandom_range(0, 3) == 0) ? 630 + $urandom_range(0, 15) : $urandom_range(0, 799),
                 20);
        end

        // clear with 1F; writes still served while pending, second request ignored
        pulse_clear(8'h1F, 100);
        for (int y = 100; y < 104; y++) line(y, 0, 16);
        pulse_clear(8'h44, 104);
        vblank(19210, -1, 9000);
        rnd_wr = 0; wr_valid = 0;
        for (int y = 0; y < 8; y++) line(y, 0, 40);

        // reset in the middle of a clear, then a fresh clear completes
        pulse_clear(8'h55, 200);
        line(200, 2, 10);
        vblank(5002, 5001, -1);
        line(481, 100, 5);
        pulse_clear(8'h77, 300);
        rnd_wr = 1;
        line(300, 2, 30);
        vblank(19210, -1, -1);
        rnd_wr = 0; wr_valid = 0;
        for (int y = 116; y < 120; y++) line(y * 4, 600, 48);
        line(0, 0, 40);

        @(negedge clock);
        #1;
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
